clk_step_ctrl: RTL

- Run-control scheduler for the CPU clock-enable path on the FPGA.
- Produces single-cycle `tick` enable pulses at a programmable divide ratio in three modes:
  - free-running (RUN)
  - counted single/multi-step (STEP)
  - stopped (HALT)
- Commands arrive from the debug/host side over a valid/ready handshake.
- Lets the core be halted, stepped N ticks, or slowed without gating the clock.

---
 rtl/clk_step_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/clk_step_ctrl.sv
// Run-control scheduler for the CPU clock-enable path: emits one-cycle tick
// pulses at a programmable divide ratio in RUN, counted STEP or HALT modes.
module clk_step_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             halt_req,
    output logic             tick,
    output logic             running,
    output logic             step_done,
    output logic [CNT_W-1:0] div_cur
);

    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);

    localparam logic [1:0] OP_HALT    = 2'b00;
    localparam logic [1:0] OP_RUN     = 2'b01;
    localparam logic [1:0] OP_STEP    = 2'b10;
    localparam logic [1:0] OP_SET_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    // A zero divisor or step count behaves as one.
    function automatic logic [CNT_W-1:0] sat_one(input logic [CNT_W-1:0] v);
        return (v == ZERO_C) ? ONE_C : v;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             running_q, running_d;

    logic             accept_s;
    logic             wrap_s;
    logic [CNT_W-1:0] arg_sat_s;

    assign cmd_ready = ~halt_req & (state_q != ST_STEP);
    assign accept_s  = cmd_valid & cmd_ready;
    assign wrap_s    = (cnt_q == (div_cur_q - ONE_C));
    assign arg_sat_s = sat_one(cmd_arg);

    assign tick      = tick_q;
    assign running   = running_q;
    assign step_done = done_q;
    assign div_cur   = div_cur_q;

    // Next-state, counter, divisor and pulse generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;

        if (halt_req) begin
            state_d   = ST_HALT;
            cnt_d     = ZERO_C;
            rem_d     = ZERO_C;
            div_cur_d = div_pend_q;
        end else begin
            case (state_q)
                ST_HALT: begin
                    cnt_d = ZERO_C;
                    if (accept_s) begin
                        case (cmd_op)
                            OP_RUN: begin
                                state_d = ST_RUN;
                            end
                            OP_STEP: begin
                                state_d = ST_STEP;
                                rem_d   = arg_sat_s;
                            end
                            OP_SET_DIV: begin
                                div_cur_d  = arg_sat_s;
                                div_pend_d = arg_sat_s;
                            end
                            default: begin
                                state_d = ST_HALT;
                            end
                        endcase
                    end else begin
                        state_d = ST_HALT;
                    end
                end
                ST_RUN: begin
                    if (accept_s && (cmd_op == OP_HALT)) begin
                        state_d   = ST_HALT;
                        cnt_d     = ZERO_C;
                        rem_d     = ZERO_C;
                        div_cur_d = div_pend_q;
                    end else if (accept_s && (cmd_op == OP_STEP)) begin
                        // Stepping out of RUN restarts the phase from zero.
                        state_d   = ST_STEP;
                        cnt_d     = ZERO_C;
                        rem_d     = arg_sat_s;
                        div_cur_d = div_pend_q;
                    end else begin
                        if (accept_s && (cmd_op == OP_SET_DIV)) begin
                            div_pend_d = arg_sat_s;
                        end else begin
                            div_pend_d = div_pend_q;
                        end
                        // A new divisor only takes effect on a wrap, so no period is mixed.
                        if (wrap_s) begin
                            cnt_d     = ZERO_C;
                            tick_d    = 1'b1;
                            div_cur_d = div_pend_d;
                        end else begin
                            cnt_d = cnt_q + ONE_C;
                        end
                    end
                end
                ST_STEP: begin
                    if (rem_q == ZERO_C) begin
                        state_d = ST_HALT;
                        cnt_d   = ZERO_C;
                    end else if (wrap_s) begin
                        cnt_d  = ZERO_C;
                        tick_d = 1'b1;
                        rem_d  = rem_q - ONE_C;
                        done_d = (rem_q == ONE_C);
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                default: begin
                    state_d = ST_HALT;
                    cnt_d   = ZERO_C;
                    rem_d   = ZERO_C;
                end
            endcase
        end

        running_d = (state_d != ST_HALT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_HALT;
            cnt_q      <= ZERO_C;
            rem_q      <= ZERO_C;
            div_cur_q  <= DEF_DIV_C;
            div_pend_q <= DEF_DIV_C;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            running_q  <= running_d;
        end
    end

endmodule
